// File: rtl/picorv32_axi_mem_pkg.sv
// Shared types and helpers for the picorv32 AXI4-Lite memory responder.
// Optional feature macro: AXI_MEM_STALL_LFSR_EN (pseudo-random latency and ready stalls).
package picorv32_axi_mem_pkg;

  // Responder FSM states; the encoding is also visible on the top's dbg_state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RESP = 3'd4
  } axi_mem_state_e;

  // Feedback taps 8,6,5,4 of the 8-bit Fibonacci LFSR (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Word index of a byte address; addr[1:0] is ignored. words must be a power of two.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) & (words - 32'd1);
  endfunction

  // True when no address bit above the word index is set.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) < words;
  endfunction

endpackage

// File: rtl/picorv32_axi_lite_mem_responder_wait_gen.sv
// Wait-state counter for the memory responder, plus the optional LFSR that
// randomises latency and stalls the readies (AXI_MEM_STALL_LFSR_EN).
module axi_mem_wait_gen
  import picorv32_axi_mem_pkg::*;
#(
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       active,
  output logic [3:0] wait_load_val,
  output logic       wait_done,
  output logic       stall
);

  logic [3:0] cnt;

  // Load on request capture, then count down to zero while a wait state is active.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= wait_load_val;
    end else if (active && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign wait_done = (cnt == 4'd0);

`ifdef AXI_MEM_STALL_LFSR_EN
  logic [7:0] lfsr;

  // Free-running LFSR; advances every clock outside reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign wait_load_val = 4'(32'(lfsr[3:0]) % (WAIT_STATES + 1));
  assign stall         = lfsr[7];
`else
  assign wait_load_val = 4'(WAIT_STATES);
  assign stall         = 1'b0;
`endif

endmodule

// File: rtl/picorv32_axi_lite_mem_responder.sv
// AXI4-Lite slave memory answering picorv32_axi_adapter's mem_axi_* port.
// Word RAM with byte strobes, fixed (or LFSR-randomised) response latency.
// Optional feature macro: AXI_MEM_STALL_LFSR_EN.
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1; readies are only ever 1 in IDLE.
module picorv32_axi_lite_mem_responder
  import picorv32_axi_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           mem_axi_awvalid,
  output logic           mem_axi_awready,
  input  logic [31:0]    mem_axi_awaddr,
  input  logic [2:0]     mem_axi_awprot,
  input  logic           mem_axi_wvalid,
  output logic           mem_axi_wready,
  input  logic [31:0]    mem_axi_wdata,
  input  logic [3:0]     mem_axi_wstrb,
  output logic           mem_axi_bvalid,
  input  logic           mem_axi_bready,
  input  logic           mem_axi_arvalid,
  output logic           mem_axi_arready,
  input  logic [31:0]    mem_axi_araddr,
  input  logic [2:0]     mem_axi_arprot,
  output logic           mem_axi_rvalid,
  input  logic           mem_axi_rready,
  output logic [31:0]    mem_axi_rdata,
  output axi_mem_state_e dbg_state
);

  localparam int IW = $clog2(MEM_WORDS);

  axi_mem_state_e state_q, state_d;
  logic        aw_held, w_held;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic [3:0]  wstrb_q;
  logic        in_idle, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic        wait_load, wait_done, stall, do_write, do_read;
  logic [3:0]  wait_load_val;
  logic [31:0] wr_word, rd_word;
  logic [31:0] mem [MEM_WORDS];

  wire unused_bits = ^{mem_axi_awprot, mem_axi_arprot, wr_word[31:IW], rd_word[31:IW], wait_load_val};

  axi_mem_wait_gen #(
    .WAIT_STATES(WAIT_STATES),
    .LFSR_SEED  (LFSR_SEED)
  ) u_wait_gen (
    .clk          (clk),
    .resetn       (resetn),
    .load         (wait_load),
    .active       ((state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT)),
    .wait_load_val(wait_load_val),
    .wait_done    (wait_done),
    .stall        (stall)
  );

  assign in_idle         = (state_q == ST_IDLE);
  assign mem_axi_awready = in_idle && !aw_held && !stall;
  assign mem_axi_wready  = in_idle && !w_held && !stall;
  assign mem_axi_arready = in_idle && !aw_held && !w_held && !mem_axi_awvalid && !mem_axi_wvalid && !stall;
  assign aw_hs           = mem_axi_awvalid && mem_axi_awready;
  assign w_hs            = mem_axi_wvalid && mem_axi_wready;
  assign ar_hs           = mem_axi_arvalid && mem_axi_arready;
  assign b_hs            = mem_axi_bvalid && mem_axi_bready;
  assign r_hs            = mem_axi_rvalid && mem_axi_rready;
  assign wr_word         = word_index(awaddr_q, MEM_WORDS);
  assign rd_word         = word_index(araddr_q, MEM_WORDS);
  assign dbg_state       = state_q;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a write completes once both AW and W are (or are becoming) held.
  always_comb begin
    state_d   = state_q;
    wait_load = 1'b0;
    do_write  = 1'b0;
    do_read   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          state_d   = ST_WR_WAIT;
          wait_load = 1'b1;
        end else if (ar_hs) begin
          state_d   = ST_RD_WAIT;
          wait_load = 1'b1;
        end
      end
      ST_WR_WAIT: if (wait_done) begin
        state_d  = ST_WR_RESP;
        do_write = 1'b1;
      end
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      ST_RD_WAIT: if (wait_done) begin
        state_d = ST_RD_RESP;
        do_read = 1'b1;
      end
      ST_RD_RESP: if (r_hs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request holding registers and the B/R response flags with read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awaddr_q       <= 32'd0;
      wdata_q        <= 32'd0;
      wstrb_q        <= 4'd0;
      araddr_q       <= 32'd0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= 32'd0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= mem_axi_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= mem_axi_wdata;
        wstrb_q <= mem_axi_wstrb;
      end
      if (ar_hs) araddr_q <= mem_axi_araddr;
      if (do_write) mem_axi_bvalid <= 1'b1;
      if (b_hs) begin
        mem_axi_bvalid <= 1'b0;
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
      end
      if (do_read) begin
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata  <= in_range(araddr_q, MEM_WORDS) ? mem[rd_word[IW-1:0]] : OOR_RDATA;
      end
      if (r_hs) mem_axi_rvalid <= 1'b0;
    end
  end

  // RAM byte-lane writes; contents survive reset and out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (do_write && in_range(awaddr_q, MEM_WORDS)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[wr_word[IW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
